tram_port_arbiter: RTL and testbench

- Shares one port of the dual-port byte-enable test RAM between two requesters, m0 and m1, e.g. the traffic generator and the checker in the DDR4 test bench.
- Arbitration is round-robin with a bounded burst per requester.
- RAM commands are issued from registers, and read data is routed back to the master that issued the read.
- Port B of the RAM stays free for a second arbiter instance or for direct use.

---
 rtl/tram_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_tram_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tram_port_arbiter
//  Purpose  : Shares one port of a dual-port byte-enable test RAM between two
//             requesters (m0, m1). Round-robin arbitration with a bounded
//             burst per requester. RAM commands are issued from registers one
//             cycle after acceptance. Read data is routed back to the master
//             that issued the read through a {valid, id} tag pipeline.
//  Ports    : clk, rst_n (async, active-low)
//             mN_req_valid_i/write_i/addr_i/wdata_i/be_i, mN_req_ready_o
//             mN_rsp_valid_o, mN_rsp_rdata_o            (N = 0, 1)
//             ram_addr_o, ram_wren_o, ram_wr_be_o, ram_data_in_o,
//             ram_rden_o, ram_data_out_i
//             stat_grant0_o, stat_grant1_o, stat_conflict_o
//                                     (only with TRAM_ARB_STATS_EN defined)
//  Options  : TRAM_ARB_STATS_EN - adds saturating 32-bit grant/conflict
//             counters and their output ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tram_port_arbiter #(
    parameter int DW        = 64,
    parameter int AW        = 10,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req_valid_i,
    input  logic            m0_req_write_i,
    input  logic [AW-1:0]   m0_req_addr_i,
    input  logic [DW-1:0]   m0_req_wdata_i,
    input  logic [DW/8-1:0] m0_req_be_i,
    output logic            m0_req_ready_o,
    output logic            m0_rsp_valid_o,
    output logic [DW-1:0]   m0_rsp_rdata_o,
    input  logic            m1_req_valid_i,
    input  logic            m1_req_write_i,
    input  logic [AW-1:0]   m1_req_addr_i,
    input  logic [DW-1:0]   m1_req_wdata_i,
    input  logic [DW/8-1:0] m1_req_be_i,
    output logic            m1_req_ready_o,
    output logic            m1_rsp_valid_o,
    output logic [DW-1:0]   m1_rsp_rdata_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic            ram_wren_o,
    output logic [DW/8-1:0] ram_wr_be_o,
    output logic [DW-1:0]   ram_data_in_o,
    output logic            ram_rden_o,
`ifdef TRAM_ARB_STATS_EN
    output logic [31:0]     stat_grant0_o,
    output logic [31:0]     stat_grant1_o,
    output logic [31:0]     stat_conflict_o,
`endif
    input  logic [DW-1:0]   ram_data_out_i
);

    localparam int            BEW         = DW / 8;
    localparam int            CW          = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] C_BURST_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0] C_ONE       = CW'(1);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    // Arbiter state
    owner_e          owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Registered RAM command
    logic [AW-1:0]   ram_addr_q;
    logic            ram_wren_q;
    logic            ram_rden_q;
    logic [BEW-1:0]  ram_wr_be_q;
    logic [DW-1:0]   ram_data_in_q;

    // Read tag pipeline: stage i is valid i+1 cycles after acceptance
    logic [RD_LAT:0] tag_v_q;
    logic [RD_LAT:0] tag_id_q;

    logic            limit;
    logic            pick0;
    logic            gnt0;
    logic            gnt1;
    logic            acc;
    owner_e          sel_id;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BEW-1:0]  sel_be;

    // When both masters request, m0 wins if it owns the port and has burst
    // budget left, or if m1 owns the port and has used up its budget.
    assign limit = (cnt_q == C_BURST_MAX);
    assign pick0 = ((owner_q == OWN_M0) && !limit) || ((owner_q == OWN_M1) && limit);
    assign gnt0  = m0_req_valid_i && (!m1_req_valid_i || pick0);
    assign gnt1  = m1_req_valid_i && (!m0_req_valid_i || !pick0);
    assign acc   = gnt0 || gnt1;

    assign m0_req_ready_o = gnt0;
    assign m1_req_ready_o = gnt1;

    always_comb begin
        sel_id    = gnt1 ? OWN_M1 : OWN_M0;
        sel_write = gnt1 ? m1_req_write_i : m0_req_write_i;
        sel_addr  = gnt1 ? m1_req_addr_i  : m0_req_addr_i;
        sel_wdata = gnt1 ? m1_req_wdata_i : m0_req_wdata_i;
        sel_be    = gnt1 ? m1_req_be_i    : m0_req_be_i;
    end

    // Burst counter resets on an idle cycle so a lone requester returning
    // later starts a fresh burst.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!m0_req_valid_i && !m1_req_valid_i) begin
            cnt_d = '0;
        end else if (sel_id == owner_q) begin
            cnt_d = limit ? cnt_q : cnt_q + C_ONE;
        end else begin
            owner_d = sel_id;
            cnt_d   = C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_M0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command registers; the address holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q    <= '0;
            ram_wren_q    <= 1'b0;
            ram_rden_q    <= 1'b0;
            ram_wr_be_q   <= '0;
            ram_data_in_q <= '0;
        end else begin
            ram_wren_q    <= acc && sel_write;
            ram_rden_q    <= acc && !sel_write;
            ram_wr_be_q   <= (acc && sel_write) ? sel_be    : '0;
            ram_data_in_q <= (acc && sel_write) ? sel_wdata : '0;
            if (acc) begin
                ram_addr_q <= sel_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q[0]  <= acc && !sel_write;
            tag_id_q[0] <= sel_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign ram_addr_o    = ram_addr_q;
    assign ram_wren_o    = ram_wren_q;
    assign ram_rden_o    = ram_rden_q;
    assign ram_wr_be_o   = ram_wr_be_q;
    assign ram_data_in_o = ram_data_in_q;

    // Read data is shared; only the valid strobe says whose it is.
    assign m0_rsp_valid_o = tag_v_q[RD_LAT] && (tag_id_q[RD_LAT] == OWN_M0);
    assign m1_rsp_valid_o = tag_v_q[RD_LAT] && (tag_id_q[RD_LAT] == OWN_M1);
    assign m0_rsp_rdata_o = ram_data_out_i;
    assign m1_rsp_rdata_o = ram_data_out_i;

`ifdef TRAM_ARB_STATS_EN
    logic [31:0] stat_grant0_q;
    logic [31:0] stat_grant1_q;
    logic [31:0] stat_conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            if (gnt0 && (stat_grant0_q != 32'hFFFF_FFFF)) begin
                stat_grant0_q <= stat_grant0_q + 32'd1;
            end
            if (gnt1 && (stat_grant1_q != 32'hFFFF_FFFF)) begin
                stat_grant1_q <= stat_grant1_q + 32'd1;
            end
            if (m0_req_valid_i && m1_req_valid_i && (stat_conflict_q != 32'hFFFF_FFFF)) begin
                stat_conflict_q <= stat_conflict_q + 32'd1;
            end
        end
    end

    assign stat_grant0_o   = stat_grant0_q;
    assign stat_grant1_o   = stat_grant1_q;
    assign stat_conflict_o = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tram_port_arbiter
//  Purpose  : Self-checking bench for tram_port_arbiter with an attached
//             registered-output byte-enable RAM model. Table-driven request
//             vectors plus hand-written sequences for burst rotation and
//             reset with a read in flight. Read responses are checked by a
//             scoreboard fed from a shadow copy of the RAM contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tram_port_arbiter;

    localparam int DW        = 64;
    localparam int AW        = 10;
    localparam int RD_LAT    = 1;
    localparam int BURST_MAX = 4;

    typedef struct {
        bit              v;
        bit              w;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [DW/8-1:0] be;
    } req_t;

    typedef struct {
        req_t r0;
        req_t r1;
        bit   e0;
        bit   e1;
    } vec_t;

    typedef struct {
        bit          id;
        logic [63:0] d;
        int          due;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            m0_req_valid, m0_req_write, m0_req_ready, m0_rsp_valid;
    logic [AW-1:0]   m0_req_addr;
    logic [DW-1:0]   m0_req_wdata, m0_rsp_rdata;
    logic [DW/8-1:0] m0_req_be;
    logic            m1_req_valid, m1_req_write, m1_req_ready, m1_rsp_valid;
    logic [AW-1:0]   m1_req_addr;
    logic [DW-1:0]   m1_req_wdata, m1_rsp_rdata;
    logic [DW/8-1:0] m1_req_be;
    logic [AW-1:0]   ram_addr;
    logic            ram_wren, ram_rden;
    logic [DW/8-1:0] ram_wr_be;
    logic [DW-1:0]   ram_data_in;
    logic [DW-1:0]   ram_q;
`ifdef TRAM_ARB_STATS_EN
    logic [31:0]     stat_grant0, stat_grant1, stat_conflict;
`endif

    tram_port_arbiter #(
        .DW        (DW),
        .AW        (AW),
        .RD_LAT    (RD_LAT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req_valid_i  (m0_req_valid),
        .m0_req_write_i  (m0_req_write),
        .m0_req_addr_i   (m0_req_addr),
        .m0_req_wdata_i  (m0_req_wdata),
        .m0_req_be_i     (m0_req_be),
        .m0_req_ready_o  (m0_req_ready),
        .m0_rsp_valid_o  (m0_rsp_valid),
        .m0_rsp_rdata_o  (m0_rsp_rdata),
        .m1_req_valid_i  (m1_req_valid),
        .m1_req_write_i  (m1_req_write),
        .m1_req_addr_i   (m1_req_addr),
        .m1_req_wdata_i  (m1_req_wdata),
        .m1_req_be_i     (m1_req_be),
        .m1_req_ready_o  (m1_req_ready),
        .m1_rsp_valid_o  (m1_rsp_valid),
        .m1_rsp_rdata_o  (m1_rsp_rdata),
        .ram_addr_o      (ram_addr),
        .ram_wren_o      (ram_wren),
        .ram_wr_be_o     (ram_wr_be),
        .ram_data_in_o   (ram_data_in),
        .ram_rden_o      (ram_rden),
`ifdef TRAM_ARB_STATS_EN
        .stat_grant0_o   (stat_grant0),
        .stat_grant1_o   (stat_grant1),
        .stat_conflict_o (stat_conflict),
`endif
        .ram_data_out_i  (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read output, per-byte write enables,
    // word i preloaded with value i.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            ram_init_done;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= 64'(i);
            ram_init_done <= 1'b1;
        end else begin
            if (ram_wren)
                for (int b = 0; b < DW/8; b++)
                    if (ram_wr_be[b]) mem[ram_addr][b*8 +: 8] <= ram_data_in[b*8 +: 8];
            if (ram_rden) ram_q <= mem[ram_addr];
        end
    end

    int   checks;
    int   failures;
    exp_t sb[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    // Expected RAM command in the current cycle
    bit            cw, cr;
    logic [AW-1:0] ca;
    logic [7:0]    cbe;
    logic [63:0]   cd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (m0_rsp_valid || m1_rsp_valid)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: actual m0=%0b m1=%0b required none", m0_rsp_valid, m1_rsp_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid_pair", {62'd0, m1_rsp_valid, m0_rsp_valid}, e.id ? 64'd2 : 64'd1);
                chk("rsp_rdata", e.id ? m1_rsp_rdata : m0_rsp_rdata, e.d);
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (rst_n && sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL rsp_missing: actual none required m%0d data=%h at cycle %0d", e.id, e.d, e.due);
        end
    end

    function automatic req_t NOP();
        req_t r;
        r.v = 0; r.w = 0; r.a = '0; r.d = '0; r.be = '0;
        return r;
    endfunction

    function automatic req_t RD(input int a);
        req_t r;
        r = NOP(); r.v = 1; r.a = AW'(a);
        return r;
    endfunction

    function automatic req_t WR(input int a, input logic [63:0] d, input logic [7:0] be);
        req_t r;
        r = NOP(); r.v = 1; r.w = 1; r.a = AW'(a); r.d = d; r.be = be;
        return r;
    endfunction

    function automatic vec_t mk(input req_t r0, input req_t r1, input bit e0, input bit e1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic drive(input req_t r0, input req_t r1);
        m0_req_valid = r0.v; m0_req_write = r0.w; m0_req_addr = r0.a;
        m0_req_wdata = r0.d; m0_req_be    = r0.be;
        m1_req_valid = r1.v; m1_req_write = r1.w; m1_req_addr = r1.a;
        m1_req_wdata = r1.d; m1_req_be    = r1.be;
    endtask

    task automatic check_cmd();
        chk("ram_wren", {63'd0, ram_wren}, {63'd0, cw});
        chk("ram_rden", {63'd0, ram_rden}, {63'd0, cr});
        chk("ram_addr", 64'(ram_addr), 64'(ca));
        if (cw) begin
            chk("ram_wr_be",   64'(ram_wr_be), 64'(cbe));
            chk("ram_data_in", ram_data_in, cd);
        end
        if (cr) begin
            chk("ram_wr_be_rd",   64'(ram_wr_be), 64'd0);
            chk("ram_data_in_rd", ram_data_in, 64'd0);
        end
    endtask

    // One clock cycle: drive, check at negedge, predict, advance.
    task automatic step(input req_t r0, input req_t r1, input bit e0, input bit e1);
        req_t r;
        exp_t e;
        drive(r0, r1);
        @(negedge clk);
        check_cmd();
        chk("m0_req_ready", {63'd0, m0_req_ready}, {63'd0, e0});
        chk("m1_req_ready", {63'd0, m1_req_ready}, {63'd0, e1});
        cw = 0; cr = 0; cbe = '0; cd = '0;
        if (e0 || e1) begin
            r  = e0 ? r0 : r1;
            ca = r.a;
            if (r.w) begin
                cw = 1; cbe = r.be; cd = r.d;
                for (int b = 0; b < 8; b++)
                    if (r.be[b]) shadow[r.a][b*8 +: 8] = r.d[b*8 +: 8];
            end else begin
                cr    = 1;
                e.id  = !e0;
                e.d   = shadow[r.a];
                e.due = cyc + 1 + RD_LAT;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_m0_req_ready", {63'd0, m0_req_ready}, 64'd0);
        chk("rst_m1_req_ready", {63'd0, m1_req_ready}, 64'd0);
        chk("rst_m0_rsp_valid", {63'd0, m0_rsp_valid}, 64'd0);
        chk("rst_m1_rsp_valid", {63'd0, m1_rsp_valid}, 64'd0);
        chk("rst_ram_wren",     {63'd0, ram_wren},     64'd0);
        chk("rst_ram_rden",     {63'd0, ram_rden},     64'd0);
        chk("rst_ram_addr",     64'(ram_addr),         64'd0);
        chk("rst_ram_wr_be",    64'(ram_wr_be),        64'd0);
        chk("rst_ram_data_in",  ram_data_in,           64'd0);
    endtask

    vec_t tbl [0:23];

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n0, n1;
        bit  exp0;

        for (int i = 0; i < (1<<AW); i++) shadow[i] = 64'(i);

        // Hand-derived grants; arbiter state (owner,cnt) noted per row.
        tbl[0]  = mk(WR(5, 64'h1122334455667788, 8'hFF), NOP(), 1, 0); // (0,1)
        tbl[1]  = mk(RD(5), NOP(), 1, 0);                                // (0,2)
        tbl[2]  = mk(NOP(), NOP(), 0, 0);                                // (0,0)
        tbl[3]  = mk(NOP(), NOP(), 0, 0);
        tbl[4]  = mk(NOP(), WR(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F), 0, 1); // (1,1)
        tbl[5]  = mk(NOP(), RD(5), 0, 1);                                // (1,2)
        tbl[6]  = mk(NOP(), NOP(), 0, 0);                                // (1,0)
        tbl[7]  = mk(NOP(), NOP(), 0, 0);
        tbl[8]  = mk(WR(1, 64'hFFFFFFFFFFFFFFFF, 8'h00), NOP(), 1, 0); // (0,1) be=0
        tbl[9]  = mk(NOP(), NOP(), 0, 0);                                // (0,0)
        tbl[10] = mk(RD(1), NOP(), 1, 0);                                // (0,1)
        tbl[11] = mk(RD(3), NOP(), 1, 0);                                // (0,2)
        tbl[12] = mk(NOP(), RD(4), 0, 1);                                // (1,1) no bubble
        tbl[13] = mk(NOP(), NOP(), 0, 0);                                // (1,0)
        tbl[14] = mk(RD(1), NOP(), 1, 0);                                // (0,1)
        tbl[15] = mk(NOP(), RD(2), 0, 1);                                // (1,1)
        tbl[16] = mk(RD(6), RD(7), 0, 1);                                // (1,2)
        tbl[17] = mk(RD(6), RD(8), 0, 1);                                // (1,3)
        tbl[18] = mk(RD(6), RD(9), 0, 1);                                // (1,4)
        tbl[19] = mk(RD(6), RD(10), 1, 0);                               // (0,1) limit hit
        tbl[20] = mk(NOP(), RD(10), 0, 1);                               // (1,1)
        tbl[21] = mk(NOP(), NOP(), 0, 0);
        tbl[22] = mk(NOP(), NOP(), 0, 0);
        tbl[23] = mk(NOP(), NOP(), 0, 0);

        rst_n = 1'b0;
        drive(NOP(), NOP());
        cw = 0; cr = 0; ca = '0; cbe = '0; cd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Burst rotation from reset: m0 x4, m1 x4, m0 x4. Each master
        // holds its request until accepted.
        n0 = 0; n1 = 0;
        for (int k = 0; k < 12; k++) begin
            exp0 = ((k / BURST_MAX) % 2) == 0;
            step(RD(16 + n0), RD(32 + n1), exp0, !exp0);
            if (exp0) n0++; else n1++;
        end
        repeat (4) step(NOP(), NOP(), 0, 0);

        for (int i = 0; i < 24; i++) step(tbl[i].r0, tbl[i].r1, tbl[i].e0, tbl[i].e1);

        // Reset while a read is on the RAM port: no response afterwards.
        step(RD(2), NOP(), 1, 0);
        drive(NOP(), NOP());
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        cw = 0; cr = 0; ca = '0; cbe = '0; cd = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step(NOP(), NOP(), 0, 0);
        step(NOP(), RD(3), 0, 1);
        repeat (4) step(NOP(), NOP(), 0, 0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
